lector_teclado: RTL and testbench
=================================

# lector_teclado

Scanner for a 4x4 matrix hex keypad (Pmod KYPD on the Nexys 2). It is the input-side counterpart of the 7-segment display multiplexer. A 2-bit column counter drives one keypad column low at a time and reads the four row lines. Each full scan frame is reduced to a single key result, which is debounced over several frames. Accepted keys are delivered as a 4-bit hex code plus a one-cycle strobe, ready to feed the display path or other logic.

## Interface
- `SCAN_DIV`, 50000: clock cycles per column step; minimum 4.
- `DEBOUNCE`, 4: consecutive identical frames required to accept a press or a release; minimum 1.
- `REPEAT_FRAMES`, 64: frames between auto-repeat strobes; used only with the macro.
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: synchronous reset, active-low.
- `filas`  in  4: keypad rows, active-low, externally pulled up.
- `columnas`  out  4: column drive, one-hot active-low.
- `tecla`  out  4: hex code of the last accepted key.
- `tecla_valida`  out  1: one-cycle strobe when a key is accepted.
- `presionada`  out  1: high while the accepted key is held.

## Operation
- `filas` passes through a 2-flop synchronizer before use.
- Prescaler counts 0..`SCAN_DIV`-1 and wraps. The terminal count is the "step" cycle.
- On a step cycle:
  - The synchronized rows are sampled for the current column.
  - The 2-bit column index advances and wraps 3->0.
  - `columnas` = ~(1 << index).
- A frame ends on the column-3 sample. Frame result is one of:
  - SINGLE(k): exactly one row/column intersection was low across the frame.
  - NONE: no intersection was low.
  - MULTI: more than one intersection was low. MULTI is treated as NONE everywhere below.
- Key map, row r / column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce FSM holds a candidate key `cand` and a counter `cnt`. It is evaluated once per frame:
  - IDLE:
    - SINGLE(k): cand=k, cnt=1. If `DEBOUNCE`=1, accept immediately; otherwise go to DEB_PRESS.
  - DEB_PRESS:
    - SINGLE(cand): cnt++. When cnt==`DEBOUNCE`, accept.
    - SINGLE(j), j!=cand: cand=j, cnt=1.
    - NONE: go to IDLE.
  - Accept means: `tecla`=cand, pulse `tecla_valida`, `presionada`=1, go to HELD.
  - HELD:
    - SINGLE(cand): stay.
    - Anything else: cnt=1, go to DEB_RELEASE. If `DEBOUNCE`=1, release immediately.
  - DEB_RELEASE:
    - SINGLE(cand): go to HELD. No new strobe.
    - Anything else: cnt++. When cnt==`DEBOUNCE`, set `presionada`=0 and go to IDLE.
- `tecla` keeps its last accepted value after release.

## Timing
- Reset values:
  - `columnas`=4'b1110 (column 0 driven).
  - `tecla`=0, `tecla_valida`=0, `presionada`=0.
  - FSM state IDLE, prescaler=0, synchronizer=4'b1111.
- Reset takes effect mid-frame or mid-debounce. Any partial frame and candidate are discarded. Scanning restarts at column 0 on the first cycle after `rst_n` goes high.
- Column settling: the drive changes on a step edge. The sample is taken `SCAN_DIV` cycles later, which covers the 2-cycle synchronizer latency.
- Let t be the column-3 step edge. FSM outputs (`tecla`, `tecla_valida`, `presionada`) update at edge t+1. `tecla_valida` is high for exactly the one cycle t+1..t+2.
- Frame period is 4·`SCAN_DIV` cycles, i.e. 4 ms at default values.
- Press latency, from a stable press to the strobe: at most (`DEBOUNCE`+1) frames + 3 cycles.

## Configuration
- `TECLADO_REPETICION_EN` defined: auto-repeat is enabled.
  - In HELD, a frame counter increments on each SINGLE(cand) frame.
  - When it reaches `REPEAT_FRAMES`, `tecla_valida` pulses again (same timing as above) and the counter clears.
  - The counter clears on entry to HELD and on the DEB_RELEASE->HELD return.
- Not defined: exactly one strobe per accepted press. The repeat counter is not synthesized.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=3.
- Reset and scan: hold `rst_n`=0, then release.
  - `columnas` sequence is 1110, 1101, 1011, 0111, repeating, each for 4 cycles.
  - All outputs are 0 until a key is accepted.
- Single press: model key "9" (r2, c2) pressed for 5 frames.
  - `tecla`=4'h9.
  - One `tecla_valida` pulse, one cycle after the column-3 step edge of the 3rd frame.
  - `presionada`=1 until 3 NONE frames after release.
- Bounce: toggle key "A" every frame for 6 frames, then hold stable.
  - No strobe during the toggling.
  - Strobe after 3 stable frames with `tecla`=4'hA.
- Multi-key: press "1" and "5" together for 10 frames.
  - No strobe; state stays IDLE.
  - Releasing "5" then yields `tecla`=4'h1 after 3 frames.
- Reset mid-debounce: press "D", assert `rst_n`=0 during the 2nd frame, release reset with the key still held.
  - Strobe occurs 3 full frames after reset, not earlier.
- With `TECLADO_REPETICION_EN` and `REPEAT_FRAMES`=2: hold "0" for 9 frames after acceptance.
  - Strobes at acceptance plus 4 repeats, all with `tecla`=4'h0.

Source files
------------

// File: rtl/lector_teclado.sv
// 4x4 hex keypad scanner: column-multiplexed row sampling, per-frame key reduction, frame debounce.
// Optional auto-repeat while a key is held, enabled by defining TECLADO_REPETICION_EN.
module lector_teclado #(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned REPEAT_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       presionada
);

  localparam int unsigned PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

  localparam logic [PW-1:0]   PMax   = PW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE);

  typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRelease} state_e;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    unique case ({r, c})
      4'd0:    k = 4'h1;
      4'd1:    k = 4'h2;
      4'd2:    k = 4'h3;
      4'd3:    k = 4'hA;
      4'd4:    k = 4'h4;
      4'd5:    k = 4'h5;
      4'd6:    k = 4'h6;
      4'd7:    k = 4'hB;
      4'd8:    k = 4'h7;
      4'd9:    k = 4'h8;
      4'd10:   k = 4'h9;
      4'd11:   k = 4'hC;
      4'd12:   k = 4'h0;
      4'd13:   k = 4'hF;
      4'd14:   k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]    sync1_q, sync2_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    col_q;
  logic          step;

  // Low intersections seen so far in the frame, saturated at 2 (= MULTI)
  logic [1:0] acc_q, acc_sat;
  logic [3:0] acc_key_q, next_key, cur_key;
  logic [2:0] col_hits, hit_sum;
  logic [1:0] row_idx;

  logic       frame_valid_q, frame_single_q;
  logic [3:0] frame_key_q;

  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      tecla_q, tecla_d;
  logic            valida_q, valida_d;
  logic            pres_q, pres_d;
  logic            hit_cand, accept, do_release;

`ifdef TECLADO_REPETICION_EN
  localparam int unsigned RepW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_FRAMES);
  logic [RepW-1:0] rep_q, rep_d, rep_inc;
`endif

  assign step         = (presc_q == PMax);
  assign columnas     = ~(4'b0001 << col_q);
  assign tecla        = tecla_q;
  assign tecla_valida = valida_q;
  assign presionada   = pres_q;

  always_comb begin
    col_hits = 3'd0;
    row_idx  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!sync2_q[r]) begin
        col_hits = col_hits + 3'd1;
        row_idx  = 2'(r);
      end
    end
    cur_key  = key_map(row_idx, col_q);
    hit_sum  = {1'b0, acc_q} + col_hits;
    acc_sat  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    next_key = (acc_q == 2'd0 && col_hits == 3'd1) ? cur_key : acc_key_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q        <= 4'b1111;
      sync2_q        <= 4'b1111;
      presc_q        <= '0;
      col_q          <= 2'd0;
      acc_q          <= 2'd0;
      acc_key_q      <= 4'h0;
      frame_valid_q  <= 1'b0;
      frame_single_q <= 1'b0;
      frame_key_q    <= 4'h0;
    end else begin
      sync1_q       <= filas;
      sync2_q       <= sync1_q;
      frame_valid_q <= 1'b0;
      if (step) begin
        presc_q <= '0;
        col_q   <= col_q + 2'd1;
        if (col_q == 2'd3) begin
          frame_valid_q  <= 1'b1;
          frame_single_q <= (acc_sat == 2'd1);
          frame_key_q    <= next_key;
          acc_q          <= 2'd0;
        end else begin
          acc_q     <= acc_sat;
          acc_key_q <= next_key;
        end
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    tecla_d    = tecla_q;
    valida_d   = 1'b0;
    pres_d     = pres_q;
    accept     = 1'b0;
    do_release = 1'b0;
    cnt_inc    = cnt_q + CntW'(1);
    hit_cand   = frame_single_q && (frame_key_q == cand_q);
`ifdef TECLADO_REPETICION_EN
    rep_d      = rep_q;
    rep_inc    = rep_q + RepW'(1);
`endif
    if (frame_valid_q) begin
      unique case (state_q)
        StIdle: begin
          if (frame_single_q) begin
            cand_d = frame_key_q;
            cnt_d  = CntW'(1);
            if (DEBOUNCE == 1) accept = 1'b1;
            else               state_d = StDebPress;
          end
        end
        StDebPress: begin
          if (hit_cand) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DebMax) accept = 1'b1;
          end else if (frame_single_q) begin
            cand_d = frame_key_q;
            cnt_d  = CntW'(1);
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          if (hit_cand) begin
`ifdef TECLADO_REPETICION_EN
            if (rep_inc == RepMax) begin
              valida_d = 1'b1;
              rep_d    = '0;
            end else begin
              rep_d = rep_inc;
            end
`endif
          end else begin
            cnt_d = CntW'(1);
            if (DEBOUNCE == 1) do_release = 1'b1;
            else               state_d = StDebRelease;
          end
        end
        default: begin
          if (hit_cand) begin
            state_d = StHeld;
`ifdef TECLADO_REPETICION_EN
            rep_d = '0;
`endif
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DebMax) do_release = 1'b1;
          end
        end
      endcase
    end
    if (accept) begin
      tecla_d  = cand_d;
      valida_d = 1'b1;
      pres_d   = 1'b1;
      state_d  = StHeld;
`ifdef TECLADO_REPETICION_EN
      rep_d = '0;
`endif
    end
    if (do_release) begin
      pres_d  = 1'b0;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cand_q   <= 4'h0;
      cnt_q    <= '0;
      tecla_q  <= 4'h0;
      valida_q <= 1'b0;
      pres_q   <= 1'b0;
`ifdef TECLADO_REPETICION_EN
      rep_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      tecla_q  <= tecla_d;
      valida_q <= valida_d;
      pres_q   <= pres_d;
`ifdef TECLADO_REPETICION_EN
      rep_q    <= rep_d;
`endif
    end
  end

endmodule

// File: tb/tb_lector_teclado.sv
// Directed bench for lector_teclado with SCAN_DIV=4, DEBOUNCE=3; a frame is 16 cycles after reset.
module tb_lector_teclado;

  localparam int unsigned SCAN_DIV      = 4;
  localparam int unsigned DEBOUNCE      = 3;
  localparam int unsigned REPEAT_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic [3:0]  tecla;
  logic        tecla_valida;
  logic        presionada;
  logic [15:0] pressed = 16'h0000;  // bit r*4+c = key at row r, column c

  int tests = 0;
  int fails = 0;

  int         cyc = 0;
  int         strobe_cnt, strobe_hi, first_strobe_cyc, last_strobe_cyc;
  int         pres_rise_cyc, pres_fall_cyc;
  logic [3:0] first_key, last_key;
  logic       valida_prev, pres_prev;

  lector_teclado #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE      (DEBOUNCE),
    .REPEAT_FRAMES (REPEAT_FRAMES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .filas        (filas),
    .columnas     (columnas),
    .tecla        (tecla),
    .tecla_valida (tecla_valida),
    .presionada   (presionada)
  );

  always #5 clk = ~clk;

  always_comb begin
    filas = 4'b1111;
    for (int r = 0; r < 4; r++) filas[r] = ~|(pressed[r*4 +: 4] & ~columnas);
  end

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      strobe_cnt       = 0;
      strobe_hi        = 0;
      first_strobe_cyc = -1;
      last_strobe_cyc  = -1;
      pres_rise_cyc    = -1;
      pres_fall_cyc    = -1;
      first_key        = 4'hx;
      last_key         = 4'hx;
      valida_prev      = 1'b0;
      pres_prev        = 1'b0;
    end else begin
      if (tecla_valida) begin
        strobe_hi++;
        if (!valida_prev) begin
          if (strobe_cnt == 0) begin
            first_strobe_cyc = cyc;
            first_key        = tecla;
          end
          strobe_cnt++;
          last_strobe_cyc = cyc;
          last_key        = tecla;
        end
      end
      if (presionada && !pres_prev) pres_rise_cyc = cyc;
      if (!presionada && pres_prev) pres_fall_cyc = cyc;
      valida_prev = tecla_valida;
      pres_prev   = presionada;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (cyc < n) begin
      tests++;
      fails++;
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    pressed = 16'h0000;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      tests++;
      if ({columnas, tecla, tecla_valida, presionada} !== {exp_col, 4'h0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset_scan[%0d]: got col=%b tecla=%h v=%b p=%b, required col=%b tecla=0 v=0 p=0",
                 i, columnas, tecla, tecla_valida, presionada, exp_col);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_single_press();
    do_reset();
    pressed = 16'h0001 << (2 * 4 + 2);
    wait_cyc(80);
    pressed = 16'h0000;
    wait_cyc(140);
    tests++;
    if (strobe_cnt !== 1) begin
      fails++; $display("FAIL single_count: got %0d required 1", strobe_cnt);
    end
    tests++;
    if (strobe_hi !== 1) begin
      fails++; $display("FAIL single_width: got %0d cycles required 1", strobe_hi);
    end
    tests++;
    if (first_strobe_cyc !== 49) begin
      fails++; $display("FAIL single_time: got cycle %0d required 49", first_strobe_cyc);
    end
    tests++;
    if (tecla !== 4'h9) begin
      fails++; $display("FAIL single_key: got %h required 9", tecla);
    end
    tests++;
    if (pres_rise_cyc !== 49) begin
      fails++; $display("FAIL single_pres_rise: got cycle %0d required 49", pres_rise_cyc);
    end
    tests++;
    if (pres_fall_cyc !== 129) begin
      fails++; $display("FAIL single_pres_fall: got cycle %0d required 129", pres_fall_cyc);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int f = 1; f <= 6; f++) begin
      wait_cyc(16 * (f - 1));
      pressed = (f % 2 == 1) ? 16'h0008 : 16'h0000;
    end
    wait_cyc(96);
    pressed = 16'h0008;
    wait_cyc(170);
    tests++;
    if (strobe_cnt !== 1) begin
      fails++; $display("FAIL bounce_count: got %0d required 1", strobe_cnt);
    end
    tests++;
    if (first_strobe_cyc !== 145) begin
      fails++; $display("FAIL bounce_time: got cycle %0d required 145", first_strobe_cyc);
    end
    tests++;
    if ({tecla, presionada} !== {4'hA, 1'b1}) begin
      fails++; $display("FAIL bounce_key: got tecla=%h p=%b required tecla=a p=1", tecla, presionada);
    end
  endtask

  task automatic test_multi_key();
    do_reset();
    tests++;
    if ({tecla, presionada} !== {4'h0, 1'b0}) begin
      fails++; $display("FAIL multi_reset: got tecla=%h p=%b required tecla=0 p=0", tecla, presionada);
    end
    pressed = 16'h0001 | (16'h0001 << 5);
    wait_cyc(160);
    tests++;
    if ({strobe_cnt, presionada} !== {32'd0, 1'b0}) begin
      fails++; $display("FAIL multi_none: got strobes=%0d p=%b required 0 0", strobe_cnt, presionada);
    end
    pressed = 16'h0001;
    wait_cyc(220);
    tests++;
    if (strobe_cnt !== 1 || first_strobe_cyc !== 209) begin
      fails++; $display("FAIL multi_release: got strobes=%0d at %0d required 1 at 209",
                        strobe_cnt, first_strobe_cyc);
    end
    tests++;
    if (tecla !== 4'h1) begin
      fails++; $display("FAIL multi_key: got %h required 1", tecla);
    end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    pressed = 16'h0001 << 15;
    wait_cyc(20);
    tests++;
    if (strobe_cnt !== 0) begin
      fails++; $display("FAIL mid_pre_reset: got %0d strobes required 0", strobe_cnt);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_cyc(60);
    tests++;
    if (strobe_cnt !== 1 || first_strobe_cyc !== 49) begin
      fails++; $display("FAIL mid_strobe: got strobes=%0d at %0d required 1 at 49",
                        strobe_cnt, first_strobe_cyc);
    end
    tests++;
    if (tecla !== 4'hD) begin
      fails++; $display("FAIL mid_key: got %h required d", tecla);
    end
  endtask

  task automatic test_repeat();
    int exp_cnt;
    int exp_last;
`ifdef TECLADO_REPETICION_EN
    exp_cnt  = 5;
    exp_last = 177;
`else
    exp_cnt  = 1;
    exp_last = 49;
`endif
    do_reset();
    pressed = 16'h0001 << 12;
    wait_cyc(192);
    pressed = 16'h0000;
    wait_cyc(260);
    tests++;
    if (strobe_cnt !== exp_cnt || strobe_hi !== exp_cnt) begin
      fails++; $display("FAIL repeat_count: got %0d strobes, %0d high cycles, required %0d",
                        strobe_cnt, strobe_hi, exp_cnt);
    end
    tests++;
    if (last_strobe_cyc !== exp_last) begin
      fails++; $display("FAIL repeat_last: got cycle %0d required %0d", last_strobe_cyc, exp_last);
    end
    tests++;
    if ({first_key, last_key} !== 8'h00) begin
      fails++; $display("FAIL repeat_key: got %h/%h required 0/0", first_key, last_key);
    end
    tests++;
    if (pres_fall_cyc !== 241 || presionada !== 1'b0) begin
      fails++; $display("FAIL repeat_release: got fall at %0d p=%b required 241 p=0",
                        pres_fall_cyc, presionada);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_reset_mid_debounce();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
